// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop sync, 16x oversampled majority-vote FSM, show-ahead FIFO.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits.
module uart_rx_core #(
    parameter int CLK_FREQ   = 20_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                          SYS_CLK,
    input  logic                          RST_N,
    input  logic                          Rxd,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    output logic                          rx_busy,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic                          parity_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = $clog2(DIV + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);

    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_core: illegal parameter set");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t               state_q, state_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic [DW-1:0]        div_q, div_d;
    logic [3:0]           tick_q, tick_d;
    logic [3:0]           bit_q, bit_d;
    logic                 s7_q, s7_d, s8_q, s8_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 bad_q, bad_d;
    logic                 fe_q, fe_d, ov_q;
    logic                 fall, start_det, tick, samp9, vote, wr;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wp_q, rp_q;
    logic [AW:0]          cnt_q, cnt_d;
    logic                 full, empty, do_rd, do_wr, ovr;

    assign fall      = rx_prev_q & ~rx_s2_q;
    assign start_det = (state_q == IDLE) & fall;
    assign tick      = (div_q == DW'(DIV - 1));
    assign samp9     = tick & (tick_q == 4'd9);
    assign vote      = (s7_q & s8_q) | (s7_q & rx_s2_q) | (s8_q & rx_s2_q);

    always_comb begin
        div_d  = (start_det || tick) ? '0 : div_q + 1'b1;
        tick_d = start_det ? 4'd0 : (tick ? tick_q + 4'd1 : tick_q);
        s7_d   = (tick && tick_q == 4'd7) ? rx_s2_q : s7_q;
        s8_d   = (tick && tick_q == 4'd8) ? rx_s2_q : s8_q;
    end

`ifdef UART_RX_PARITY_EN
    logic pe_q, pe_d;
`endif

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        bad_d   = bad_q;
        fe_d    = 1'b0;
        wr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: if (fall) begin
                state_d = START;
                bad_d   = 1'b0;
                bit_d   = '0;
            end
            START: if (samp9) begin
                state_d = vote ? IDLE : DATA;
                bit_d   = '0;
            end
            DATA: if (samp9) begin
                shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (bit_q == 4'(DATA_BITS - 1)) begin
                    bit_d = '0;
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (samp9) begin
                if (vote != ((^shift_q) ^ 1'(PARITY_ODD))) begin
                    pe_d  = 1'b1;
                    bad_d = 1'b1;
                end
                state_d = STOP;
            end
`endif
            STOP: if (samp9) begin
                if (!vote) begin
                    fe_d    = 1'b1;
                    state_d = BREAK;
                end else if (bit_q == 4'(STOP_BITS - 1)) begin
                    // Leave at mid-stop so the next start edge is not missed
                    wr      = ~bad_q;
                    state_d = IDLE;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            BREAK: if (rx_s2_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr & (~full | do_rd);
    assign ovr   = wr & full & ~do_rd;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            div_q     <= '0;
            tick_q    <= '0;
            bit_q     <= '0;
            s7_q      <= 1'b1;
            s8_q      <= 1'b1;
            shift_q   <= '0;
            bad_q     <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rx_s1_q   <= Rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            div_q     <= div_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            s7_q      <= s7_d;
            s8_q      <= s8_d;
            shift_q   <= shift_d;
            bad_q     <= bad_d;
            fe_q      <= fe_d;
            ov_q      <= ovr;
            wp_q      <= do_wr ? wp_q + 1'b1 : wp_q;
            rp_q      <= do_rd ? rp_q + 1'b1 : rp_q;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (do_wr) mem[wp_q] <= shift_q;
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) pe_q <= 1'b0;
        else        pe_q <= pe_d;
    end
    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_valid    = ~empty;
    assign rx_data     = empty ? '0 : mem[rp_q];
    assign rx_busy     = (state_q != IDLE);
    assign frame_err   = fe_q;
    assign overrun_err = ov_q;
    assign fifo_count  = cnt_q;

endmodule
